// File: rtl/gate_truth_table_checker_if.sv
// Handshake and result bus between the gate truth-table checker and its
// environment (start request, gate stimulus/response, run results).
//   master : drives start and returns the gate block outputs
//   slave  : the checker; drives stimulus a/b and the run status/results
interface gate_truth_table_checker_if;
    localparam int unsigned ERR_W = 3;
    localparam int unsigned MAP_W = 4;

    logic             start;
    logic             a;
    logic             b;
    logic             nand_in;
    logic             nor_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [MAP_W-1:0] fail_vec;

    modport master (
        output start, nand_in, nor_in,
        input  a, b, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, nand_in, nor_in,
        output a, b, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_truth_table_checker.sv
// Stimulus/compare stage for the mux-based universal gate block. On start it
// drives {a,b} = 00,01,10,11, waits SETTLE_CYCLES per vector, samples the
// returned NAND/NOR values one cycle later and records per-vector failures.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus.start  : run request, honoured only when idle
//   bus.a/b    : stimulus to the gate block
//   bus.nand_in/nor_in : gate block outputs
//   bus.busy/done/pass/err_count/fail_vec : run status and results (registered)
module gate_truth_table_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    gate_truth_table_checker_if.slave   bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned VEC_W = 2;
    localparam int unsigned ERR_W = 3;
    localparam int unsigned MAP_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(3);

    logic [1:0]       state_q,  state_d;
    logic [VEC_W-1:0] vec_q,    vec_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             a_q,      a_d;
    logic             b_q,      b_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             pass_q,   pass_d;
    logic [ERR_W-1:0] err_q,    err_d;
    logic [MAP_W-1:0] fail_q,   fail_d;
    logic             mismatch_c;

    // Gate response check against the currently driven vector
    assign mismatch_c = (bus.nand_in != ~(a_q & b_q)) |
                        (bus.nor_in  != ~(a_q | b_q));

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SETTLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fail_d  = '0;
                end
            end

            ST_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                if (mismatch_c) begin
                    fail_d = fail_q | (MAP_W'(1) << vec_q);
                    err_d  = err_q + ERR_W'(1);
                end
                if (vec_q != VEC_LAST) begin
                    state_d    = ST_SETTLE;
                    vec_d      = vec_q + VEC_W'(1);
                    {a_d, b_d} = vec_q + VEC_W'(1);
                    cnt_d      = '0;
                end else begin
                    // Last vector: pass covers this vector's result too
                    state_d = ST_IDLE;
                    vec_d   = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = ~mismatch_c & (fail_q == '0);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_q;

    // The settle counter is 4 bits wide and a zero-cycle settle is meaningless
    settle_cycles_legal_a: assert property (@(posedge clk)
        (SETTLE_CYCLES != 0) && (SETTLE_CYCLES < 16))
        else $error("gate_truth_table_checker: SETTLE_CYCLES=%0d outside 1..15", SETTLE_CYCLES);

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: two instances (SETTLE_CYCLES 2 and 1)
// driving a behavioural gate block with selectable faults.
module tb_gate_truth_table_checker;
    logic       clk;
    logic       rst_n;
    logic [1:0] start_v;
    int         gmode;
    logic [3:0] gmask;
    int         n_checks;
    int         n_fail;

    gate_truth_table_checker_if if0 ();
    gate_truth_table_checker_if if1 ();

    gate_truth_table_checker #(.SETTLE_CYCLES(2)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    gate_truth_table_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate block model: mode 0 healthy, 1 nand stuck-1, 2 nand/nor swapped,
    // 3 nor stuck-0, 4 both inverted, 5 nand flipped on vectors in mask
    function automatic logic [1:0] gate_out(input int mode, input logic [3:0] mask,
                                            input logic a, input logic b);
        logic n;
        logic r;
        logic [1:0] idx;
        n   = !(a && b);
        r   = !(a || b);
        idx = {a, b};
        case (mode)
            1:       return {1'b1, r};
            2:       return {r, n};
            3:       return {n, 1'b0};
            4:       return {!n, !r};
            5:       return {n ^ mask[idx], r};
            default: return {n, r};
        endcase
    endfunction

    // Expected failure map derived from the truth table of NAND/NOR
    function automatic logic [3:0] exp_fail(input int mode, input logic [3:0] mask);
        logic [3:0] f;
        f = '0;
        for (int k = 0; k < 4; k++) begin
            logic       va;
            logic       vb;
            logic [1:0] g;
            va = (k >= 2);
            vb = (k % 2 == 1);
            g  = gate_out(mode, mask, va, vb);
            f[k] = (g[1] != !(va && vb)) || (g[0] != !(va || vb));
        end
        return f;
    endfunction

    logic [1:0] g0;
    logic [1:0] g1;
    always_comb g0 = gate_out(gmode, gmask, if0.a, if0.b);
    always_comb g1 = gate_out(gmode, gmask, if1.a, if1.b);
    assign if0.nand_in = g0[1];
    assign if0.nor_in  = g0[0];
    assign if1.nand_in = g1[1];
    assign if1.nor_in  = g1[0];
    assign if0.start   = start_v[0];
    assign if1.start   = start_v[1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sample(input int sel, output logic oa, output logic ob,
                          output logic obusy, output logic odone, output logic opass,
                          output logic [2:0] oerr, output logic [3:0] ofail);
        if (sel == 0) begin
            oa = if0.a; ob = if0.b; obusy = if0.busy; odone = if0.done;
            opass = if0.pass; oerr = if0.err_count; ofail = if0.fail_vec;
        end else begin
            oa = if1.a; ob = if1.b; obusy = if1.busy; odone = if1.done;
            opass = if1.pass; oerr = if1.err_count; ofail = if1.fail_vec;
        end
    endtask

    task automatic check_all_zero(input int sel, input string tag);
        logic oa, ob, obusy, odone, opass;
        logic [2:0] oerr;
        logic [3:0] ofail;
        sample(sel, oa, ob, obusy, odone, opass, oerr, ofail);
        chk({tag, " ab"},   32'({oa, ob}), 0);
        chk({tag, " busy"}, 32'(obusy), 0);
        chk({tag, " done"}, 32'(odone), 0);
        chk({tag, " pass"}, 32'(opass), 0);
        chk({tag, " err"},  32'(oerr), 0);
        chk({tag, " fail"}, 32'(ofail), 0);
    endtask

    // One full run checked cycle by cycle from the accepting edge to done.
    // With hold, start stays high and the next call starts back-to-back.
    task automatic do_run(input int sel, input int s, input int mode, input logic [3:0] mask,
                          input bit repulse, input bit hold);
        logic oa, ob, obusy, odone, opass;
        logic [2:0] oerr;
        logic [3:0] ofail;
        logic [3:0] ef;
        logic [4:0] dm;
        int total;
        int nv;
        gmode = mode;
        gmask = mask;
        ef    = exp_fail(mode, mask);
        total = 4 * (s + 1);
        if (!start_v[sel]) begin
            @(negedge clk);
            start_v[sel] = 1'b1;
        end
        for (int c = 0; c <= total; c++) begin
            @(negedge clk);
            if (c == 0 && !hold) start_v[sel] = 1'b0;
            if (repulse && c == 5) start_v[sel] = 1'b1;
            if (repulse && c == 6 && !hold) start_v[sel] = 1'b0;
            sample(sel, oa, ob, obusy, odone, opass, oerr, ofail);
            if (c < total) begin
                nv = c / (s + 1);
                dm = (5'd1 << nv) - 5'd1;
                chk($sformatf("run c=%0d busy", c), 32'(obusy), 1);
                chk($sformatf("run c=%0d done", c), 32'(odone), 0);
                chk($sformatf("run c=%0d ab", c),   32'({oa, ob}), 32'(nv));
                chk($sformatf("run c=%0d pass", c), 32'(opass), 0);
                chk($sformatf("run c=%0d fail", c), 32'(ofail), 32'(ef & dm[3:0]));
                chk($sformatf("run c=%0d err", c),  32'(oerr), 32'($countones(ef & dm[3:0])));
            end else begin
                chk("end busy", 32'(obusy), 0);
                chk("end done", 32'(odone), 1);
                chk("end ab",   32'({oa, ob}), 0);
                chk("end fail", 32'(ofail), 32'(ef));
                chk("end err",  32'(oerr), 32'($countones(ef)));
                chk("end pass", 32'(opass), 32'(ef == 4'd0));
            end
        end
        if (!hold) begin
            @(negedge clk);
            sample(sel, oa, ob, obusy, odone, opass, oerr, ofail);
            chk("post done",  32'(odone), 0);
            chk("post busy",  32'(obusy), 0);
            chk("post pass",  32'(opass), 32'(ef == 4'd0));
            chk("post fail",  32'(ofail), 32'(ef));
        end
    endtask

    typedef struct {
        int         mode;
        logic [3:0] fail_vec;
        logic [2:0] err_count;
        logic       pass;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic oa, ob, obusy, odone, opass;
        logic [2:0] oerr;
        logic [3:0] ofail;
        n_checks = 0;
        n_fail   = 0;
        start_v  = '0;
        gmode    = 0;
        gmask    = '0;
        rst_n    = 1'b0;

        tbl[0] = '{0, 4'b0000, 3'd0, 1'b1};
        tbl[1] = '{1, 4'b1000, 3'd1, 1'b0};
        tbl[2] = '{2, 4'b0110, 3'd2, 1'b0};
        tbl[3] = '{3, 4'b0001, 3'd1, 1'b0};
        tbl[4] = '{4, 4'b1111, 3'd4, 1'b0};

        repeat (3) @(negedge clk);
        check_all_zero(0, "reset0");
        check_all_zero(1, "reset1");
        rst_n = 1'b1;

        // Fixed fault table on the SETTLE_CYCLES=2 instance
        for (int i = 0; i < 5; i++) begin
            do_run(0, 2, tbl[i].mode, 4'd0, 1'b0, 1'b0);
            sample(0, oa, ob, obusy, odone, opass, oerr, ofail);
            chk($sformatf("tbl%0d fail_vec", i),  32'(ofail), 32'(tbl[i].fail_vec));
            chk($sformatf("tbl%0d err_count", i), 32'(oerr),  32'(tbl[i].err_count));
            chk($sformatf("tbl%0d pass", i),      32'(opass), 32'(tbl[i].pass));
        end

        // start re-pulsed while busy must not disturb the run
        do_run(0, 2, 0, 4'd0, 1'b1, 1'b0);

        // start held high: back-to-back runs, results cleared on re-acceptance
        do_run(0, 2, 1, 4'd0, 1'b0, 1'b1);
        do_run(0, 2, 0, 4'd0, 1'b0, 1'b0);

        // Reset during the second vector's settle window
        gmode = 4;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        sample(0, oa, ob, obusy, odone, opass, oerr, ofail);
        chk("pre-rst ab",  32'({oa, ob}), 1);
        chk("pre-rst err", 32'(oerr), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero(0, "midrst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sample(0, oa, ob, obusy, odone, opass, oerr, ofail);
            chk("midrst hold done", 32'(odone), 0);
            chk("midrst hold busy", 32'(obusy), 0);
        end
        rst_n = 1'b1;
        do_run(0, 2, 0, 4'd0, 1'b0, 1'b0);

        // Randomized fault patterns against the truth-table model
        for (int i = 0; i < 8; i++) begin
            int   m;
            logic [3:0] mk;
            m  = int'($urandom_range(0, 5));
            mk = 4'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_run(0, 2, m, mk, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Shortest legal settle window
        do_run(1, 1, 0, 4'd0, 1'b0, 1'b0);
        do_run(1, 1, 2, 4'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gate_truth_table_checker.md
Name: gate_truth_table_checker

Overview:
- Self-checking stimulus/compare stage for the mux-based universal gate block (a, b in; nand_gate, nor_gate out).
- Sits directly upstream of that block and consumes its outputs. Drives all four {a,b} vectors in order, waits a settle window, and compares the returned NAND/NOR values against expected.
- Reports a per-vector fail map, an error count and a pass flag. Used in on-chip self-test and as a reusable bench component.

Parameters:
- SETTLE_CYCLES, 2, cycles between driving a vector and its sample cycle; legal range 1..15. 0 is illegal; a simulation-time check must fire on it.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a 4-vector run; sampled only in IDLE
- a  output  1  stimulus to gate block input a
- b  output  1  stimulus to gate block input b
- nand_in  input  1  gate block nand_gate output
- nor_in  input  1  gate block nor_gate output
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse at run completion
- pass  output  1  1 when the last completed run had zero mismatches
- err_count  output  3  number of failing vectors in the last run (0..4)
- fail_vec  output  4  bit k set if vector k failed; k = {a,b} as a 2-bit value

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - While rst_n=0, immediately: state=IDLE, a=b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, vec_idx=0, settle counter=0.
  - Reset mid-run aborts the run with no done pulse.
- States: IDLE, SETTLE, SAMPLE. Registered outputs only; no combinational path from nand_in or nor_in to any output.
- IDLE:
  - done=0 except in the completion cycle.
  - On an edge with start=1 (edge E0): vec_idx=0, {a,b}=00, cnt=0, busy=1, pass=0, err_count=0, fail_vec=0, go to SETTLE.
- SETTLE: cnt increments each edge. At the edge where cnt reaches SETTLE_CYCLES-1, go to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE: lasts one cycle. At its closing edge:
  - expected nand = ~(a&b); expected nor = ~(a|b).
  - A mismatch on either signal sets fail_vec[vec_idx] and increments err_count.
  - If vec_idx<3: vec_idx++, {a,b}=vec_idx+1, cnt=0, go to SETTLE.
  - If vec_idx=3: go to IDLE. busy=0, done=1 for exactly one cycle, a=b=0. pass=1 iff no mismatch over all four vectors, including this one.
- Vector order is fixed: 00, 01, 10, 11. Each vector occupies SETTLE_CYCLES+1 cycles.
- Latency: done is high in the cycle after edge E0+4*(SETTLE_CYCLES+1), i.e. 12 edges after start with the default.
- start while busy=1 is ignored, with no restart and no queuing.
- start held high: a new run is accepted at the first edge after the done cycle. Results are cleared at that acceptance edge.
- pass, err_count and fail_vec hold their values from completion until the next accepted start.
- err_count cannot overflow (max 4). It counts vectors, not individual signal mismatches.

Test Plan:
- Healthy gate block connected, SETTLE_CYCLES=2, start pulsed one cycle → a,b step through 00,01,10,11 with 3 cycles each; done pulses 12 edges after the start edge; pass=1, err_count=0, fail_vec=0000, busy low afterwards.
- nand_in forced to 1 → only vector 11 fails: fail_vec=1000, err_count=1, pass=0.
- nand_in and nor_in swapped → vectors 01 and 10 fail: fail_vec=0110, err_count=2, pass=0.
- rst_n pulsed low during the 2nd vector's SETTLE → all outputs go to 0 immediately with no done pulse. A following start completes a clean run with pass=1.
- start re-pulsed during a run (busy=1) → ignored; done is still at edge 12. start held high continuously → back-to-back runs; the second run begins at the edge after the done cycle and pass is cleared at that edge.
- SETTLE_CYCLES=1 with a healthy block → 2 cycles per vector, done 8 edges after start, pass=1.
